// File: rtl/reg_file_sb_if.sv
// Decode/writeback bus for the scoreboarded register file.
interface reg_file_sb_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 2
);
  localparam int unsigned NREGS = 1 << AW;

  logic [AW-1:0]    rr1;
  logic [AW-1:0]    rr2;
  logic             re1;
  logic             re2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;
  logic [AW-1:0]    wr;
  logic [WIDTH-1:0] wd;
  logic             regwrite;
  logic             issue_valid;
  logic [AW-1:0]    issue_rd;
  logic             issue_ready;
  logic             busy1;
  logic             busy2;
  logic             hazard;
  logic [NREGS-1:0] pending;

  // Pipeline side: decode and writeback stages.
  modport master (
    output rr1, rr2, re1, re2, wr, wd, regwrite, issue_valid, issue_rd,
    input  rd1, rd2, issue_ready, busy1, busy2, hazard, pending
  );

  // Register file side.
  modport slave (
    input  rr1, rr2, re1, re2, wr, wd, regwrite, issue_valid, issue_rd,
    output rd1, rd2, issue_ready, busy1, busy2, hazard, pending
  );
endinterface

// File: rtl/reg_file_sb.sv
// N x W register file with optional zero register, write-to-read bypass
// and a per-register pending-write scoreboard that drives the decode stall.
module reg_file_sb #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned AW       = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic         clock,
  input  logic         reset_n,
  reg_file_sb_if.slave bus
);
  localparam int unsigned NREGS = 1 << AW;

  logic [WIDTH-1:0] mem [NREGS];
  logic [NREGS-1:0] pend;
  logic [NREGS-1:0] set_v;
  logic [NREGS-1:0] clr_v;
  logic             we;
  logic             busy1_c;
  logic             busy2_c;
  logic             hazard_c;
  logic             ready_c;

  // Writes to the hardwired zero register are dropped.
  assign we = bus.regwrite & ~(ZERO_REG & (bus.wr == '0));

  // Per-register scoreboard set (accepted issue) and clear (writeback) strobes.
  always_comb begin
    set_v = '0;
    clr_v = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      set_v[i] = bus.issue_valid & ready_c & (bus.issue_rd == AW'(i));
      clr_v[i] = bus.regwrite & (bus.wr == AW'(i));
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    if (ZERO_REG && (g == 0)) begin : g_zero
      assign mem[g]  = '0;
      assign pend[g] = 1'b0;
    end else begin : g_impl
      logic [WIDTH-1:0] data_q;
      logic             pend_q;

      // Data storage, written at the rising edge by writeback.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          data_q <= '0;
        end else if (we && (bus.wr == AW'(g))) begin
          data_q <= bus.wd;
        end
      end

      // Pending bit: a new producer supersedes the retiring one.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          pend_q <= 1'b0;
        end else if (set_v[g]) begin
          pend_q <= 1'b1;
        end else if (clr_v[g]) begin
          pend_q <= 1'b0;
        end
      end

      assign mem[g]  = data_q;
      assign pend[g] = pend_q;
    end
  end

  // Combinational read ports with optional same-cycle forwarding.
  always_comb begin
    bus.rd1 = mem[bus.rr1];
    bus.rd2 = mem[bus.rr2];
    if (BYPASS && we && (bus.wr == bus.rr1)) bus.rd1 = bus.wd;
    if (BYPASS && we && (bus.wr == bus.rr2)) bus.rd2 = bus.wd;
  end

  // Effective busy status; with bypass a retiring write releases immediately.
  always_comb begin
    busy1_c  = pend[bus.rr1] & ~(BYPASS & clr_v[bus.rr1]);
    busy2_c  = pend[bus.rr2] & ~(BYPASS & clr_v[bus.rr2]);
    hazard_c = (bus.re1 & busy1_c) | (bus.re2 & busy2_c);
    ready_c  = ~hazard_c;
  end

  assign bus.busy1       = busy1_c;
  assign bus.busy2       = busy2_c;
  assign bus.hazard      = hazard_c;
  assign bus.issue_ready = ready_c;
  assign bus.pending     = pend;
endmodule

// File: tb/tb_reg_file_sb.sv
// Scoreboard bench for reg_file_sb: a 16-bit/4-entry bypassing instance and
// a 32-bit/8-entry non-bypassing instance.
module tb_reg_file_sb;
  logic clk;
  logic rst_n;

  reg_file_sb_if #(.WIDTH(16), .AW(2)) ifa ();
  reg_file_sb_if #(.WIDTH(32), .AW(3)) ifb ();

  reg_file_sb #(.WIDTH(16), .AW(2), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .clock(clk), .reset_n(rst_n), .bus(ifa)
  );
  reg_file_sb #(.WIDTH(32), .AW(3), .ZERO_REG(1'b1), .BYPASS(1'b0)) dut_b (
    .clock(clk), .reset_n(rst_n), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          dut;
    string       name;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [3:0]  flags;   // {busy1, busy2, hazard, issue_ready}
    logic [7:0]  pend;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s.%s: got 0x%0h, expected 0x%0h", name, field, act, expv);
    end
  endtask

  // Monitor: outputs are combinational, so compare away from the edge.
  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      exp_t        e;
      logic [31:0] a_rd1, a_rd2;
      logic [3:0]  a_fl;
      logic [7:0]  a_pd;
      e = exp_q.pop_front();
      if (e.dut) begin
        a_rd1 = ifb.rd1;
        a_rd2 = ifb.rd2;
        a_fl  = {ifb.busy1, ifb.busy2, ifb.hazard, ifb.issue_ready};
        a_pd  = ifb.pending;
      end else begin
        a_rd1 = 32'(ifa.rd1);
        a_rd2 = 32'(ifa.rd2);
        a_fl  = {ifa.busy1, ifa.busy2, ifa.hazard, ifa.issue_ready};
        a_pd  = 8'(ifa.pending);
      end
      chk(e.name, "rd1", a_rd1, e.rd1);
      chk(e.name, "rd2", a_rd2, e.rd2);
      chk(e.name, "flags", 32'(a_fl), 32'(e.flags));
      chk(e.name, "pending", 32'(a_pd), 32'(e.pend));
    end
  end

  task automatic expect_out(input bit dut, input string name,
                            input logic [31:0] rd1, input logic [31:0] rd2,
                            input logic [3:0] flags, input logic [7:0] pend);
    exp_t e;
    e.dut = dut; e.name = name; e.rd1 = rd1; e.rd2 = rd2;
    e.flags = flags; e.pend = pend;
    exp_q.push_back(e);
  endtask

  task automatic a_drive(input logic [7:0] rr1, input logic [7:0] rr2,
                         input logic re1, input logic re2,
                         input logic [7:0] wr, input logic [31:0] wd,
                         input logic rw, input logic iv, input logic [7:0] ird);
    ifa.rr1 = 2'(rr1); ifa.rr2 = 2'(rr2); ifa.re1 = re1; ifa.re2 = re2;
    ifa.wr = 2'(wr); ifa.wd = 16'(wd); ifa.regwrite = rw;
    ifa.issue_valid = iv; ifa.issue_rd = 2'(ird);
  endtask

  task automatic b_drive(input logic [7:0] rr1, input logic [7:0] rr2,
                         input logic re1, input logic re2,
                         input logic [7:0] wr, input logic [31:0] wd,
                         input logic rw, input logic iv, input logic [7:0] ird);
    ifb.rr1 = 3'(rr1); ifb.rr2 = 3'(rr2); ifb.re1 = re1; ifb.re2 = re2;
    ifb.wr = 3'(wr); ifb.wd = wd; ifb.regwrite = rw;
    ifb.issue_valid = iv; ifb.issue_rd = 3'(ird);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    a_drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    b_drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out(0, "a_reset", 0, 0, 4'b0001, 8'h00);
    expect_out(1, "b_reset", 0, 0, 4'b0001, 8'h00);
    step();
    step();
    rst_n = 1'b1;

    // ---- 16-bit, 4 registers, bypass ----
    a_drive(1, 0, 0, 0, 1, 32'h1234, 1, 1, 2);
    expect_out(0, "a_wr_bypass", 32'h1234, 0, 4'b0001, 8'h00);
    step();
    a_drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out(0, "a_wr_stored", 32'h1234, 0, 4'b0001, 8'h04);
    step();
    #2 rst_n = 1'b0;
    expect_out(0, "a_async_reset", 0, 0, 4'b0001, 8'h00);
    expect_out(1, "b_async_reset_idle", 0, 0, 4'b0001, 8'h00);
    step();
    rst_n = 1'b1;

    a_drive(0, 0, 0, 0, 0, 32'hFFFF, 1, 0, 0);
    expect_out(0, "a_zero_wr", 0, 0, 4'b0001, 8'h00);
    step();
    a_drive(0, 0, 1, 0, 0, 0, 0, 1, 0);
    expect_out(0, "a_zero_issue", 0, 0, 4'b0001, 8'h00);
    step();
    a_drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    expect_out(0, "a_zero_not_pending", 0, 0, 4'b0001, 8'h00);
    step();

    a_drive(0, 2, 0, 0, 2, 32'h00A5, 1, 0, 0);
    expect_out(0, "a_bypass_same", 0, 32'h00A5, 4'b0001, 8'h00);
    step();
    a_drive(0, 2, 0, 0, 0, 0, 0, 0, 0);
    expect_out(0, "a_bypass_after", 0, 32'h00A5, 4'b0001, 8'h00);
    step();

    a_drive(0, 2, 0, 0, 0, 0, 0, 1, 3);
    expect_out(0, "a_issue_r3", 0, 32'h00A5, 4'b0001, 8'h00);
    step();
    a_drive(3, 2, 1, 0, 0, 0, 0, 1, 2);
    expect_out(0, "a_stall", 0, 32'h00A5, 4'b1010, 8'h08);
    step();
    a_drive(3, 2, 0, 0, 0, 0, 0, 0, 0);
    expect_out(0, "a_stall_no_set", 0, 32'h00A5, 4'b1001, 8'h08);
    step();

    a_drive(3, 2, 1, 0, 3, 32'h0016, 1, 0, 0);
    expect_out(0, "a_release", 32'h0016, 32'h00A5, 4'b0001, 8'h08);
    step();
    a_drive(3, 2, 1, 0, 0, 0, 0, 0, 0);
    expect_out(0, "a_released", 32'h0016, 32'h00A5, 4'b0001, 8'h00);
    step();

    a_drive(1, 2, 0, 0, 0, 0, 0, 1, 1);
    expect_out(0, "a_issue_r1", 0, 32'h00A5, 4'b0001, 8'h00);
    step();
    a_drive(1, 2, 0, 0, 1, 32'hBEEF, 1, 1, 1);
    expect_out(0, "a_set_clr", 32'hBEEF, 32'h00A5, 4'b0001, 8'h02);
    step();
    a_drive(1, 2, 0, 0, 0, 0, 0, 0, 0);
    expect_out(0, "a_set_wins", 32'hBEEF, 32'h00A5, 4'b1001, 8'h02);
    step();
    a_drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // ---- 32-bit, 8 registers, no bypass ----
    b_drive(7, 0, 0, 0, 7, 32'hDEADBEEF, 1, 1, 5);
    expect_out(1, "b_wr_no_bypass", 0, 0, 4'b0001, 8'h00);
    step();
    b_drive(7, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out(1, "b_wr_stored", 32'hDEADBEEF, 0, 4'b0001, 8'h20);
    step();

    b_drive(0, 0, 0, 0, 0, 32'hFFFFFFFF, 1, 0, 0);
    expect_out(1, "b_zero_wr", 0, 0, 4'b0001, 8'h20);
    step();
    b_drive(0, 0, 1, 0, 0, 0, 0, 1, 0);
    expect_out(1, "b_zero_issue", 0, 0, 4'b0001, 8'h20);
    step();
    b_drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
    expect_out(1, "b_zero_not_pending", 0, 0, 4'b0001, 8'h20);
    step();

    b_drive(0, 2, 0, 0, 2, 32'hA5A5A5A5, 1, 0, 0);
    expect_out(1, "b_old_before_edge", 0, 0, 4'b0001, 8'h20);
    step();
    b_drive(0, 2, 0, 0, 0, 0, 0, 0, 0);
    expect_out(1, "b_new_after_edge", 0, 32'hA5A5A5A5, 4'b0001, 8'h20);
    step();

    b_drive(5, 2, 1, 0, 0, 0, 0, 1, 2);
    expect_out(1, "b_stall", 0, 32'hA5A5A5A5, 4'b1010, 8'h20);
    step();
    b_drive(5, 2, 0, 0, 0, 0, 0, 0, 0);
    expect_out(1, "b_stall_no_set", 0, 32'hA5A5A5A5, 4'b1001, 8'h20);
    step();

    b_drive(5, 2, 1, 0, 5, 32'h0016, 1, 0, 0);
    expect_out(1, "b_release_late", 0, 32'hA5A5A5A5, 4'b1010, 8'h20);
    step();
    b_drive(5, 2, 1, 0, 0, 0, 0, 0, 0);
    expect_out(1, "b_released", 32'h0016, 32'hA5A5A5A5, 4'b0001, 8'h00);
    step();

    b_drive(7, 0, 0, 0, 0, 0, 0, 1, 7);
    expect_out(1, "b_issue_r7", 32'hDEADBEEF, 0, 4'b0001, 8'h00);
    step();
    b_drive(7, 0, 0, 0, 7, 32'h12345678, 1, 1, 7);
    expect_out(1, "b_set_clr", 32'hDEADBEEF, 0, 4'b1001, 8'h80);
    step();
    b_drive(7, 0, 0, 0, 0, 0, 0, 0, 0);
    expect_out(1, "b_set_wins", 32'h12345678, 0, 4'b1001, 8'h80);
    step();

    #2 rst_n = 1'b0;
    expect_out(1, "b_async_reset", 0, 0, 4'b0001, 8'h00);
    step();
    step();

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
